// File: rtl/grf_wb_sched_if.sv
// grf_wb_sched_if: signal bundle between the GRF write-port scheduler and its
// neighbours (W stage, long-latency result source, issue and decode stages,
// and the GRF write port itself).
//   slave  : the scheduler's view of the bundle
//   master : the surrounding pipeline's view of the bundle
interface grf_wb_sched_if;
  logic        a_we;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic [31:0] a_pc;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic [31:0] b_pc;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [4:0]  q1_addr;
  logic [4:0]  q2_addr;
  logic        q1_pend;
  logic        q2_pend;
  logic        hold_a;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;
  logic        busy;

  modport slave (
    input  a_we, a_addr, a_data, a_pc,
    input  b_valid, b_addr, b_data, b_pc,
    input  iss_valid, iss_addr, q1_addr, q2_addr,
    output b_ready, q1_pend, q2_pend, hold_a,
    output grf_we, grf_a3, grf_wd, grf_pc, busy
  );

  modport master (
    output a_we, a_addr, a_data, a_pc,
    output b_valid, b_addr, b_data, b_pc,
    output iss_valid, iss_addr, q1_addr, q2_addr,
    input  b_ready, q1_pend, q2_pend, hold_a,
    input  grf_we, grf_a3, grf_wd, grf_pc, busy
  );
endinterface

// File: rtl/grf_wb_sched.sv
// grf_wb_sched: shares the single GRF write port between the W stage (A,
// zero latency, always wins) and a buffered long-latency source (B, drained
// on cycles A does not write). A pending scoreboard lets decode stall on
// registers still awaiting a B result; a starvation timer freezes the
// pipeline for one cycle so a blocked B entry is guaranteed to drain.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : grf_wb_sched_if.slave (A request, B handshake, issue/query,
//            hold_a, GRF write port, busy)
//
// state  | meaning
// NORMAL | A has priority; B drains only when A is not writing
// HOLD   | pipeline frozen for one cycle; FIFO head is written unconditionally
module grf_wb_sched #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input logic           clk,
  input logic           reset,
  grf_wb_sched_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ST_NORMAL, ST_HOLD} state_t;

  state_t        state_q, state_d;
  logic [4:0]    fifo_addr_q [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pend_q, pend_d;
  logic [WW-1:0] wait_q, wait_d;

  logic a_eff;
  logic fifo_empty;
  logic push;
  logic pop;
  logic blocked;
  logic hold_a;

  assign a_eff      = bus.a_we && (bus.a_addr != 5'd0);
  assign fifo_empty = (count_q == '0);
  // Readiness depends only on the registered count: a full FIFO refuses even
  // when it is popping this cycle, keeping b_ready off the grant path.
  assign bus.b_ready = (count_q < CW'(DEPTH));
  // r0 results are consumed but never stored: nothing to write, nothing to clear.
  assign push    = bus.b_valid && bus.b_ready && (bus.b_addr != 5'd0);
  assign pop     = !fifo_empty && (hold_a || !a_eff);
  assign blocked = !fifo_empty && !pop;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_NORMAL;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: if (blocked && (wait_q == WW'(STARVE_LIMIT - 1))) state_d = ST_HOLD;
      ST_HOLD:   state_d = ST_NORMAL;
      default:   state_d = ST_NORMAL;
    endcase
  end

  // FSM: outputs
  always_comb begin
    hold_a = 1'b0;
    case (state_q)
      ST_HOLD: hold_a = 1'b1;
      default: hold_a = 1'b0;
    endcase
  end

  // Starvation timer counts consecutive blocked cycles; any pop or an empty
  // FIFO restarts it.
  always_comb begin
    wait_d = wait_q;
    if (!blocked)                           wait_d = '0;
    else if (wait_q != WW'(STARVE_LIMIT))   wait_d = wait_q + WW'(1);
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Clear happens first so a same-cycle re-issue to the popped register wins.
  always_comb begin
    pend_d = pend_q;
    if (pop)           pend_d[fifo_addr_q[rd_ptr_q]] = 1'b0;
    if (bus.iss_valid) pend_d[bus.iss_addr]          = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      wait_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      wait_q   <= wait_d;
    end
  end

  // Entry storage needs no reset: count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.b_addr;
      fifo_data_q[wr_ptr_q] <= bus.b_data;
      fifo_pc_q[wr_ptr_q]   <= bus.b_pc;
    end
  end

  always_comb begin
    bus.grf_we = 1'b0;
    bus.grf_a3 = fifo_addr_q[rd_ptr_q];
    bus.grf_wd = fifo_data_q[rd_ptr_q];
    bus.grf_pc = fifo_pc_q[rd_ptr_q];
    if (hold_a || !a_eff) begin
      bus.grf_we = !fifo_empty;
    end else begin
      bus.grf_we = 1'b1;
      bus.grf_a3 = bus.a_addr;
      bus.grf_wd = bus.a_data;
      bus.grf_pc = bus.a_pc;
    end
    if (reset) bus.grf_we = 1'b0;
  end

  assign bus.hold_a  = hold_a;
  assign bus.q1_pend = pend_q[bus.q1_addr];
  assign bus.q2_pend = pend_q[bus.q2_addr];
  assign bus.busy    = !fifo_empty || (pend_q != '0);

endmodule

// File: tb/tb_grf_wb_sched.sv
// tb_grf_wb_sched: directed vector table, a starvation sequence, and a
// randomized run checked against a queue-based reference model.
module tb_grf_wb_sched;
  localparam int DEPTH = 2;
  localparam int LIMIT = 8;
  localparam logic [31:0] PCK = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_wb_sched_if bus();

  grf_wb_sched #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic awe, input logic [4:0] aaddr,
                       input logic [31:0] adata, input logic bv, input logic [4:0] baddr,
                       input logic [31:0] bdata, input logic iv, input logic [4:0] iaddr,
                       input logic [4:0] q1, input logic [4:0] q2);
    reset         = rst;
    bus.a_we      = awe;
    bus.a_addr    = aaddr;
    bus.a_data    = adata;
    bus.a_pc      = adata ^ PCK;
    bus.b_valid   = bv;
    bus.b_addr    = baddr;
    bus.b_data    = bdata;
    bus.b_pc      = bdata ^ PCK;
    bus.iss_valid = iv;
    bus.iss_addr  = iaddr;
    bus.q1_addr   = q1;
    bus.q2_addr   = q2;
  endtask

  typedef struct {
    logic        rst;
    logic        a_we;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        bv;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        iv;
    logic [4:0]  i_addr;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic        e_hold;
    logic        e_q1p;
    logic        e_q2p;
    logic        e_busy;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic awe, input logic [4:0] aaddr,
                              input logic [31:0] adata, input logic bv, input logic [4:0] baddr,
                              input logic [31:0] bdata, input logic iv, input logic [4:0] iaddr,
                              input logic [4:0] q1, input logic [4:0] q2,
                              input logic ewe, input logic [4:0] ea3, input logic [31:0] ewd,
                              input logic erdy, input logic ehold, input logic eq1p,
                              input logic eq2p, input logic ebusy);
    vec_t v;
    v.rst = rst; v.a_we = awe; v.a_addr = aaddr; v.a_data = adata;
    v.bv = bv; v.b_addr = baddr; v.b_data = bdata; v.iv = iv; v.i_addr = iaddr;
    v.q1 = q1; v.q2 = q2; v.e_we = ewe; v.e_a3 = ea3; v.e_wd = ewd;
    v.e_rdy = erdy; v.e_hold = ehold; v.e_q1p = eq1p; v.e_q2p = eq2p; v.e_busy = ebusy;
    return v;
  endfunction

  vec_t vt[25];

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  task automatic run_table();
    vt[0]  = mk(1, 0,0,0,            0,0,0,             0,0, 0,0, 0,0,0,            1,0,0,0,0);
    vt[1]  = mk(0, 0,0,0,            1,5,32'h11111111,  0,0, 5,0, 0,0,0,            1,0,0,0,0);
    vt[2]  = mk(0, 0,0,0,            0,0,0,             0,0, 5,0, 1,5,32'h11111111, 1,0,0,0,1);
    vt[3]  = mk(0, 0,0,0,            0,0,0,             0,0, 5,0, 0,0,0,            1,0,0,0,0);
    vt[4]  = mk(0, 1,7,32'h77,       1,1,32'h01,        0,0, 1,2, 1,7,32'h77,       1,0,0,0,0);
    vt[5]  = mk(0, 1,7,32'h78,       1,2,32'h02,        0,0, 1,2, 1,7,32'h78,       1,0,0,0,1);
    vt[6]  = mk(0, 0,0,0,            1,3,32'h03,        0,0, 1,2, 1,1,32'h01,       0,0,0,0,1);
    vt[7]  = mk(0, 0,0,0,            1,3,32'h03,        0,0, 1,2, 1,2,32'h02,       1,0,0,0,1);
    vt[8]  = mk(0, 0,0,0,            0,0,0,             0,0, 1,2, 1,3,32'h03,       1,0,0,0,1);
    vt[9]  = mk(0, 0,0,0,            0,0,0,             0,0, 1,2, 0,0,0,            1,0,0,0,0);
    vt[10] = mk(0, 0,0,0,            1,9,32'h99,        1,9, 9,9, 0,0,0,            1,0,0,0,0);
    vt[11] = mk(0, 0,0,0,            0,0,0,             1,9, 9,9, 1,9,32'h99,       1,0,1,1,1);
    vt[12] = mk(0, 0,0,0,            0,0,0,             0,0, 9,9, 0,0,0,            1,0,1,1,1);
    vt[13] = mk(0, 0,0,0,            1,9,32'h9A,        0,0, 9,0, 0,0,0,            1,0,1,0,1);
    vt[14] = mk(0, 0,0,0,            0,0,0,             0,0, 9,0, 1,9,32'h9A,       1,0,1,0,1);
    vt[15] = mk(0, 0,0,0,            0,0,0,             0,0, 9,0, 0,0,0,            1,0,0,0,0);
    vt[16] = mk(0, 0,0,0,            1,0,32'hDEAD,      0,0, 0,0, 0,0,0,            1,0,0,0,0);
    vt[17] = mk(0, 0,0,0,            0,0,0,             0,0, 0,0, 0,0,0,            1,0,0,0,0);
    vt[18] = mk(0, 1,0,32'h1234,     1,6,32'h66,        0,0, 6,0, 0,0,0,            1,0,0,0,0);
    vt[19] = mk(0, 1,0,32'h1234,     0,0,0,             0,0, 6,0, 1,6,32'h66,       1,0,0,0,1);
    vt[20] = mk(0, 0,0,0,            0,0,0,             0,0, 6,0, 0,0,0,            1,0,0,0,0);
    vt[21] = mk(0, 1,3,32'h33,       1,10,32'hA0,       1,4, 4,0, 1,3,32'h33,       1,0,0,0,0);
    vt[22] = mk(0, 1,3,32'h34,       1,11,32'hB0,       0,0, 4,0, 1,3,32'h34,       1,0,1,0,1);
    vt[23] = mk(1, 1,3,32'h35,       0,0,0,             0,0, 4,0, 0,0,0,            0,0,1,0,1);
    vt[24] = mk(0, 0,0,0,            0,0,0,             0,0, 4,0, 0,0,0,            1,0,0,0,0);

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive(vt[i].rst, vt[i].a_we, vt[i].a_addr, vt[i].a_data, vt[i].bv, vt[i].b_addr,
            vt[i].b_data, vt[i].iv, vt[i].i_addr, vt[i].q1, vt[i].q2);
      #1;
      chk($sformatf("vec%0d_we", i), 32'(bus.grf_we), 32'(vt[i].e_we));
      if (vt[i].e_we) begin
        chk($sformatf("vec%0d_a3", i), 32'(bus.grf_a3), 32'(vt[i].e_a3));
        chk($sformatf("vec%0d_wd", i), bus.grf_wd, vt[i].e_wd);
        chk($sformatf("vec%0d_pc", i), bus.grf_pc, vt[i].e_wd ^ PCK);
      end
      chk($sformatf("vec%0d_b_ready", i), 32'(bus.b_ready), 32'(vt[i].e_rdy));
      chk($sformatf("vec%0d_hold_a", i), 32'(bus.hold_a), 32'(vt[i].e_hold));
      chk($sformatf("vec%0d_q1_pend", i), 32'(bus.q1_pend), 32'(vt[i].e_q1p));
      chk($sformatf("vec%0d_q2_pend", i), 32'(bus.q2_pend), 32'(vt[i].e_q2p));
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vt[i].e_busy));
    end
  endtask

  task automatic run_starve();
    int   blocked_cycles;
    logic seen;
    logic [4:0]  hold_a3;
    logic [31:0] hold_wd;
    blocked_cycles = 0;
    seen = 1'b0;
    hold_a3 = '0;
    hold_wd = '0;
    @(negedge clk);
    drive(0, 1,3,32'h300, 0,0,0, 1,8, 8,0);
    @(negedge clk);
    drive(0, 1,3,32'h301, 1,8,32'h88, 0,0, 8,0);
    #1;
    chk("starve_q1_pend_r8", 32'(bus.q1_pend), 32'd1);
    chk("starve_a_wins", 32'(bus.grf_a3), 32'd3);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      drive(0, 1,3,32'h310 + 32'(k), 0,0,0, 0,0, 8,0);
      #1;
      if (bus.hold_a) begin
        seen = 1'b1;
        hold_a3 = bus.grf_a3;
        hold_wd = bus.grf_wd;
      end else begin
        blocked_cycles++;
        chk("starve_blocked_a3", 32'(bus.grf_a3), 32'd3);
        chk("starve_blocked_q1_pend", 32'(bus.q1_pend), 32'd1);
      end
    end
    chk("starve_hold_seen", 32'(seen), 32'd1);
    chk("starve_blocked_cycles", 32'(blocked_cycles), 32'(LIMIT));
    chk("starve_hold_a3", 32'(hold_a3), 32'd8);
    chk("starve_hold_wd", hold_wd, 32'h88);
    @(negedge clk);
    drive(0, 1,3,32'h3FF, 0,0,0, 0,0, 8,0);
    #1;
    chk("starve_after_hold_a", 32'(bus.hold_a), 32'd0);
    chk("starve_after_q1_pend", 32'(bus.q1_pend), 32'd0);
    chk("starve_after_a3", 32'(bus.grf_a3), 32'd3);
    chk("starve_after_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic run_random(input int n);
    ent_t        q[$];
    bit          pend[32];
    int          run;
    bit          hold_m;
    logic        rst, awe, bv, iv, aeff, sel_b, popping, blocked, e_we, any_pend;
    logic [4:0]  aaddr, baddr, iaddr, q1, q2, e_a3;
    logic [31:0] adata, bdata, e_wd, e_pc;
    ent_t        e;
    run = 0;
    hold_m = 0;
    for (int i = 0; i < 32; i++) pend[i] = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rst   = (c == 0) || ($urandom_range(0, 199) == 0);
      awe   = ($urandom_range(0, 99) < 85);
      aaddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      adata = $urandom;
      bv    = ($urandom_range(0, 2) != 0);
      baddr = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bdata = $urandom;
      iv    = ($urandom_range(0, 3) == 0);
      iaddr = 5'($urandom_range(0, 31));
      q1    = 5'($urandom_range(0, 31));
      q2    = 5'($urandom_range(0, 31));
      drive(rst, awe, aaddr, adata, bv, baddr, bdata, iv, iaddr, q1, q2);
      #1;
      aeff  = awe && (aaddr != 0);
      sel_b = hold_m || !aeff;
      if (sel_b) begin
        e_we = (q.size() > 0);
        e_a3 = e_we ? q[0].addr : 5'd0;
        e_wd = e_we ? q[0].data : 32'd0;
        e_pc = e_we ? q[0].pc   : 32'd0;
      end else begin
        e_we = 1'b1;
        e_a3 = aaddr;
        e_wd = adata;
        e_pc = adata ^ PCK;
      end
      if (rst) e_we = 1'b0;
      any_pend = 1'b0;
      for (int r = 0; r < 32; r++) if (pend[r]) any_pend = 1'b1;
      if (c > 0) begin
        chk("rnd_we", 32'(bus.grf_we), 32'(e_we));
        if (e_we) begin
          chk("rnd_a3", 32'(bus.grf_a3), 32'(e_a3));
          chk("rnd_wd", bus.grf_wd, e_wd);
          chk("rnd_pc", bus.grf_pc, e_pc);
        end
        chk("rnd_b_ready", 32'(bus.b_ready), 32'(q.size() < DEPTH));
        chk("rnd_hold_a", 32'(bus.hold_a), 32'(hold_m));
        chk("rnd_q1_pend", 32'(bus.q1_pend), 32'(pend[q1]));
        chk("rnd_q2_pend", 32'(bus.q2_pend), 32'(pend[q2]));
        chk("rnd_busy", 32'(bus.busy), 32'((q.size() > 0) || any_pend));
      end
      if (rst) begin
        q.delete();
        for (int r = 0; r < 32; r++) pend[r] = 0;
        run = 0;
        hold_m = 0;
      end else begin
        popping = (q.size() > 0) && sel_b;
        blocked = (q.size() > 0) && !popping;
        if (bv && (q.size() < DEPTH) && (baddr != 0)) begin
          e.addr = baddr;
          e.data = bdata;
          e.pc   = bdata ^ PCK;
        end
        if (popping) begin
          pend[q[0].addr] = 0;
          void'(q.pop_front());
        end
        if (bv && (q.size() + (popping ? 1 : 0) < DEPTH) && (baddr != 0)) q.push_back(e);
        if (iv && (iaddr != 0)) pend[iaddr] = 1;
        run = blocked ? run + 1 : 0;
        hold_m = blocked && (run == LIMIT);
      end
    end
  endtask

  initial begin
    drive(1, 0,0,0, 0,0,0, 0,0, 0,0);
    repeat (2) @(posedge clk);
    run_table();
    run_starve();
    run_random(3000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
